// File: rtl/gpu_blitter.sv
// gpu_blitter: CHIP-8 / SCHIP display engine.
// Executes CLEAR (zero the whole framebuffer) and DRAW (XOR an 8-pixel-wide
// sprite into the framebuffer, with collision detect) against a framebuffer
// held in main memory at FB_OFFSET, row-major, MSB = leftmost pixel.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   gpu_cmd                  4'h1 CLEAR, 4'h2 DRAW, anything else ignored
//   gpu_draw_offset/x/y/length  DRAW operands (sprite base, position, rows)
//   gpu_cmd_submitted        command strobe, taken only while gpu_ready
//   gpu_ready                high while idle
//   gpu_collision            sticky: some DRAW pixel turned off by last DRAW
//   gpu_mem_read*            read request held until gpu_mem_read_ack
//   gpu_mem_write*           single-cycle write strobe, always accepted
module gpu_blitter #(
    parameter int FB_WIDTH  = 64,
    parameter int FB_HEIGHT = 32,
    parameter int FB_OFFSET = 'h100,
    parameter int ADDR_W    = 12,
    parameter bit WRAP      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        gpu_cmd,
    input  logic [15:0]       gpu_draw_offset,
    input  logic [7:0]        gpu_draw_x,
    input  logic [7:0]        gpu_draw_y,
    input  logic [7:0]        gpu_draw_length,
    input  logic              gpu_cmd_submitted,
    output logic              gpu_ready,
    output logic              gpu_collision,
    output logic              gpu_mem_read,
    output logic [ADDR_W-1:0] gpu_mem_read_addr,
    input  logic [7:0]        gpu_mem_read_data,
    input  logic              gpu_mem_read_ack,
    output logic              gpu_mem_write,
    output logic [ADDR_W-1:0] gpu_mem_write_addr,
    output logic [7:0]        gpu_mem_write_data
);

    localparam int BPR      = FB_WIDTH / 8;
    localparam int FB_BYTES = BPR * FB_HEIGHT;
    localparam int IDX_W    = $clog2(FB_BYTES + 1);

    localparam logic [ADDR_W-1:0] FB_BASE   = ADDR_W'(FB_OFFSET);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FB_BYTES - 1);
    localparam logic [3:0]        CMD_CLEAR = 4'h1;
    localparam logic [3:0]        CMD_DRAW  = 4'h2;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_CLEAR, S_ROW, S_FETCH, S_RD_FB, S_WR_FB
    } state_t;

    state_t state_q, state_d;

    logic [3:0]        cmd_q;
    logic [ADDR_W-1:0] off_q;
    logic [7:0]        x_q, y_q, len_q, r_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        sprite_q, old_q;
    logic              part_q;          // 0 = left byte, 1 = right byte
    logic [ADDR_W-1:0] row_base_q;
    logic              coll_q;

    // Row geometry: y0 + r can reach 510, so the sum is kept 9 bits wide.
    logic [8:0]  y_sum, y_mod;
    logic        row_in;
    logic [31:0] row_off;
    assign y_sum   = {1'b0, y_q} + {1'b0, r_q};
    assign y_mod   = 9'(32'(y_sum) % FB_HEIGHT);
    assign row_in  = (32'(y_sum) < FB_HEIGHT);
    assign row_off = 32'(y_mod) * BPR;

    // Byte split of the sprite: shifting {s,0} right by sh puts the left
    // mask in the upper byte and the spill-over into the lower byte.
    logic [7:0]  bx, right_byte, cur_byte, cur_mask;
    logic [2:0]  sh;
    logic [15:0] wide;
    logic        right_at_edge, has_right;
    logic [ADDR_W-1:0] fb_addr;
    assign bx            = x_q >> 3;
    assign sh            = x_q[2:0];
    assign wide          = {sprite_q, 8'h00} >> sh;
    assign right_at_edge = (32'(bx) + 32'd1 == BPR);
    assign right_byte    = right_at_edge ? 8'd0 : bx + 8'd1;
    assign has_right     = (sh != 3'd0) && (WRAP || !right_at_edge);
    assign cur_byte      = part_q ? right_byte : bx;
    assign cur_mask      = part_q ? wide[7:0] : wide[15:8];
    assign fb_addr       = row_base_q + ADDR_W'(cur_byte);

    logic unused_ok;
    assign unused_ok = ^gpu_draw_offset[15:ADDR_W];

    assign gpu_ready     = (state_q == S_IDLE);
    assign gpu_collision = coll_q;

    always_comb begin
        state_d            = state_q;
        gpu_mem_read       = 1'b0;
        gpu_mem_read_addr  = '0;
        gpu_mem_write      = 1'b0;
        gpu_mem_write_addr = '0;
        gpu_mem_write_data = '0;
        case (state_q)
            S_IDLE: if (gpu_cmd_submitted) state_d = S_DECODE;
            S_DECODE: begin
                if (cmd_q == CMD_CLEAR)     state_d = S_CLEAR;
                else if (cmd_q == CMD_DRAW) state_d = S_ROW;
                else                        state_d = S_IDLE;
            end
            S_CLEAR: begin
                gpu_mem_write      = 1'b1;
                gpu_mem_write_addr = FB_BASE + ADDR_W'(idx_q);
                if (idx_q == IDX_LAST) state_d = S_IDLE;
            end
            S_ROW: begin
                // Clipped mode: once a row falls off the bottom, so do all later ones.
                if (r_q == len_q)          state_d = S_IDLE;
                else if (!row_in && !WRAP) state_d = S_IDLE;
                else                       state_d = S_FETCH;
            end
            S_FETCH: begin
                gpu_mem_read      = 1'b1;
                gpu_mem_read_addr = off_q + ADDR_W'(r_q);
                if (gpu_mem_read_ack) state_d = S_RD_FB;
            end
            S_RD_FB: begin
                gpu_mem_read      = 1'b1;
                gpu_mem_read_addr = fb_addr;
                if (gpu_mem_read_ack) state_d = S_WR_FB;
            end
            S_WR_FB: begin
                gpu_mem_write      = 1'b1;
                gpu_mem_write_addr = fb_addr;
                gpu_mem_write_data = old_q ^ cur_mask;
                if (!part_q && has_right) state_d = S_RD_FB;
                else                      state_d = S_ROW;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE && cmd_q == CMD_DRAW)
                coll_q <= 1'b0;
            else if (state_q == S_WR_FB && (old_q & cur_mask) != 8'h00)
                coll_q <= 1'b1;
        end
    end

    // Datapath registers carry no reset; the state register gates their use.
    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: begin
                if (gpu_cmd_submitted) begin
                    cmd_q <= gpu_cmd;
                    off_q <= gpu_draw_offset[ADDR_W-1:0];
                    x_q   <= 8'(32'(gpu_draw_x) % FB_WIDTH);
                    y_q   <= 8'(32'(gpu_draw_y) % FB_HEIGHT);
                    len_q <= gpu_draw_length;
                end
            end
            S_DECODE: begin
                idx_q <= '0;
                r_q   <= 8'd0;
            end
            S_CLEAR: idx_q <= idx_q + IDX_W'(1);
            S_ROW:   row_base_q <= FB_BASE + ADDR_W'(row_off);
            S_FETCH: begin
                if (gpu_mem_read_ack) begin
                    sprite_q <= gpu_mem_read_data;
                    part_q   <= 1'b0;
                end
            end
            S_RD_FB: if (gpu_mem_read_ack) old_q <= gpu_mem_read_data;
            S_WR_FB: begin
                if (!part_q && has_right) part_q <= 1'b1;
                else                      r_q    <= r_q + 8'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpu_blitter.sv
module tb_gpu_blitter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cmd;
    logic [15:0] off;
    logic [7:0]  dx, dy, dlen;
    logic        sub   [2];
    logic        ready [2];
    logic        coll  [2];
    logic        rd    [2];
    logic [11:0] raddr [2];
    logic [7:0]  rdata [2] = '{8'h00, 8'h00};
    logic        ack   [2] = '{1'b0, 1'b0};
    logic        wr    [2];
    logic [11:0] waddr [2];
    logic [7:0]  wdata [2];

    int wcnt [2] = '{0, 0};
    int ack_dly = 0;
    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [4096];
    logic [20:0] exp_q [$];

    always #5 clk = ~clk;

    gpu_blitter #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .gpu_cmd(cmd), .gpu_draw_offset(off),
        .gpu_draw_x(dx), .gpu_draw_y(dy), .gpu_draw_length(dlen),
        .gpu_cmd_submitted(sub[0]), .gpu_ready(ready[0]), .gpu_collision(coll[0]),
        .gpu_mem_read(rd[0]), .gpu_mem_read_addr(raddr[0]),
        .gpu_mem_read_data(rdata[0]), .gpu_mem_read_ack(ack[0]),
        .gpu_mem_write(wr[0]), .gpu_mem_write_addr(waddr[0]),
        .gpu_mem_write_data(wdata[0])
    );

    gpu_blitter #(.WRAP(1'b0)) u_clip (
        .clk(clk), .rst(rst), .gpu_cmd(cmd), .gpu_draw_offset(off),
        .gpu_draw_x(dx), .gpu_draw_y(dy), .gpu_draw_length(dlen),
        .gpu_cmd_submitted(sub[1]), .gpu_ready(ready[1]), .gpu_collision(coll[1]),
        .gpu_mem_read(rd[1]), .gpu_mem_read_addr(raddr[1]),
        .gpu_mem_read_data(rdata[1]), .gpu_mem_read_ack(ack[1]),
        .gpu_mem_write(wr[1]), .gpu_mem_write_addr(waddr[1]),
        .gpu_mem_write_data(wdata[1])
    );

    function automatic logic [20:0] ar(input logic [11:0] a);
        return {1'b0, a, 8'h00};
    endfunction

    function automatic logic [20:0] aw(input logic [11:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [20:0] got);
        logic [20:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected access got=%0d:%03h:%02h expected=none",
                     name, got[20], got[19:8], got[7:0]);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s got=%0d:%03h:%02h expected=%0d:%03h:%02h",
                         name, got[20], got[19:8], got[7:0], e[20], e[19:8], e[7:0]);
            end
        end
    endtask

    // Memory model: acks reads after ack_dly idle cycles, commits writes,
    // and hands every completed access to the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ack[i]  = 1'b0;
                wcnt[i] = 0;
            end else begin
                if (wr[i]) begin
                    chk("rd_wr_exclusive", 32'(rd[i]), 32'd0);
                    sb_pop("write", aw(waddr[i], wdata[i]));
                    mem[waddr[i]] = wdata[i];
                end
                if (ack[i]) begin
                    ack[i]  = 1'b0;
                    wcnt[i] = 0;
                end else if (rd[i]) begin
                    if (wcnt[i] >= ack_dly) begin
                        ack[i]   = 1'b1;
                        rdata[i] = mem[raddr[i]];
                        sb_pop("read", ar(raddr[i]));
                    end else begin
                        wcnt[i]++;
                    end
                end
            end
        end
    end

    typedef struct {
        int               inst;
        logic [3:0]       cmd;
        logic [15:0]      off;
        logic [7:0]       x, y, len;
        int               dly;
        logic             coll;
        int               cyc;     // 0 = latency not checked
        int               n;
        logic [11:0][20:0] acc;
    } vec_t;

    localparam int NV = 9;
    vec_t vt [NV];

    task automatic mk(input int v, input int inst, input logic [3:0] c, input logic [15:0] o,
                      input logic [7:0] x, input logic [7:0] y, input logic [7:0] l,
                      input int dly, input logic cl, input int cyc);
        vt[v].inst = inst; vt[v].cmd = c; vt[v].off = o;
        vt[v].x = x; vt[v].y = y; vt[v].len = l;
        vt[v].dly = dly; vt[v].coll = cl; vt[v].cyc = cyc;
        vt[v].n = 0; vt[v].acc = '0;
    endtask

    task automatic add(input int v, input logic [20:0] a);
        vt[v].acc[vt[v].n] = a;
        vt[v].n++;
    endtask

    task automatic submit(input int inst, input logic [3:0] c, input logic [15:0] o,
                          input logic [7:0] x, input logic [7:0] y, input logic [7:0] l);
        @(negedge clk);
        cmd = c; off = o; dx = x; dy = y; dlen = l;
        sub[inst] = 1'b1;
        @(posedge clk);
        #1;
        sub[inst] = 1'b0;
        cmd = 4'h0; off = 16'hBEEF; dx = 8'hEE; dy = 8'hDD; dlen = 8'hCC;
    endtask

    task automatic wait_ready(input int inst, output int n);
        bit done = 1'b0;
        n = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            n++;
            if (ready[inst]) done = 1'b1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout inst=%0d got=0 expected=1", inst);
        end
    endtask

    task automatic run_clear(input bit pulse);
        int  n = 0;
        bit  done = 1'b0;
        for (int k = 0; k < 256; k++) exp_q.push_back(aw(12'(32'h100 + k), 8'h00));
        submit(0, 4'h1, 16'h0000, 8'd0, 8'd0, 8'd0);
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            n++;
            if (pulse && n == 50) begin
                cmd = 4'h2; off = 16'h0200; dlen = 8'd1; sub[0] = 1'b1;
            end
            if (n == 51) sub[0] = 1'b0;
            if (ready[0]) done = 1'b1;
        end
        chk("clear_cycles_to_ready", 32'(n), 32'd258);
        chk("clear_all_strobes_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;

        rst = 1'b1;
        cmd = 4'h0; off = 16'h0; dx = 8'h0; dy = 8'h0; dlen = 8'h0;
        sub[0] = 1'b0; sub[1] = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        for (int a = 'h100; a < 'h200; a++) mem[a] = 8'hA5;
        mem['h200] = 8'hF0;
        mem['h210] = 8'hFF;
        mem['h220] = 8'hFF;
        mem['h221] = 8'h81;

        // Draw vectors: instance 0 wraps, instance 1 clips.
        mk(0, 0, 4'h2, 16'h0200, 8'd8, 8'd0, 8'd1, 0, 1'b0, 0);
        add(0, ar(12'h200)); add(0, ar(12'h101)); add(0, aw(12'h101, 8'hF0));
        mk(1, 0, 4'h2, 16'h0200, 8'd8, 8'd2, 8'd1, 3, 1'b0, 0);
        add(1, ar(12'h200)); add(1, ar(12'h111)); add(1, aw(12'h111, 8'hF0));
        mk(2, 0, 4'h2, 16'h0210, 8'd4, 8'd1, 8'd1, 0, 1'b0, 0);
        add(2, ar(12'h210)); add(2, ar(12'h108)); add(2, aw(12'h108, 8'h0F));
        add(2, ar(12'h109)); add(2, aw(12'h109, 8'hF0));
        mk(3, 0, 4'h2, 16'h0210, 8'd4, 8'd1, 8'd1, 1, 1'b1, 0);
        add(3, ar(12'h210)); add(3, ar(12'h108)); add(3, aw(12'h108, 8'h00));
        add(3, ar(12'h109)); add(3, aw(12'h109, 8'h00));
        mk(4, 0, 4'hF, 16'h0200, 8'd0, 8'd0, 8'd1, 0, 1'b1, 2);
        mk(5, 0, 4'h2, 16'h0200, 8'd0, 8'd0, 8'd0, 0, 1'b0, 3);
        mk(6, 0, 4'h2, 16'h0220, 8'd60, 8'd31, 8'd2, 0, 1'b0, 0);
        add(6, ar(12'h220)); add(6, ar(12'h1FF)); add(6, aw(12'h1FF, 8'h0F));
        add(6, ar(12'h1F8)); add(6, aw(12'h1F8, 8'hF0));
        add(6, ar(12'h221)); add(6, ar(12'h107)); add(6, aw(12'h107, 8'h08));
        add(6, ar(12'h100)); add(6, aw(12'h100, 8'h10));
        mk(7, 1, 4'h2, 16'h0220, 8'd60, 8'd31, 8'd2, 0, 1'b1, 0);
        add(7, ar(12'h220)); add(7, ar(12'h1FF)); add(7, aw(12'h1FF, 8'h00));
        mk(8, 0, 4'h2, 16'h0200, 8'd72, 8'd34, 8'd1, 2, 1'b1, 0);
        add(8, ar(12'h200)); add(8, ar(12'h111)); add(8, aw(12'h111, 8'h00));

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", 32'(ready[i]), 32'd1);
            chk("reset_collision", 32'(coll[i]), 32'd0);
            chk("reset_read", 32'(rd[i]), 32'd0);
            chk("reset_write", 32'(wr[i]), 32'd0);
        end
        #1 rst = 1'b0;

        run_clear(1'b1);

        for (int v = 0; v < NV; v++) begin
            ack_dly = vt[v].dly;
            for (int k = 0; k < vt[v].n; k++) exp_q.push_back(vt[v].acc[k]);
            submit(vt[v].inst, vt[v].cmd, vt[v].off, vt[v].x, vt[v].y, vt[v].len);
            wait_ready(vt[v].inst, n);
            if (vt[v].cyc != 0) chk($sformatf("vec%0d_cycles", v), 32'(n), 32'(vt[v].cyc));
            chk($sformatf("vec%0d_collision", v), 32'(coll[vt[v].inst]), 32'(vt[v].coll));
            chk($sformatf("vec%0d_accesses_left", v), 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        // Reset while a framebuffer read is outstanding.
        ack_dly = 10;
        exp_q.push_back(ar(12'h200));
        submit(0, 4'h2, 16'h0200, 8'd8, 8'd0, 8'd1);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (rd[0] && raddr[0] == 12'h101) seen = 1'b1;
        end
        chk("rst_reached_fb_read", 32'(seen), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_read_low", 32'(rd[0]), 32'd0);
        chk("rst_write_low", 32'(wr[0]), 32'd0);
        chk("rst_ready_high", 32'(ready[0]), 32'd1);
        chk("rst_collision_low", 32'(coll[0]), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        chk("rst_sprite_read_only", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        ack_dly = 0;
        run_clear(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_blitter.md
Name: gpu_blitter

Overview:
CHIP-8 display engine. It executes CLEAR and DRAW commands issued by the CPU core against a framebuffer that lives in main memory. DRAW implements the full XOR-sprite semantics: arbitrary pixel x, row clipping or wrapping, two-byte straddle for unaligned x, and a sticky collision flag. Framebuffer geometry, base address and edge mode are parameters, so the same block serves CHIP-8 (64x32) and SCHIP (128x64).

Parameters:
FB_WIDTH, 64, framebuffer width in pixels; multiple of 8; FB_BYTES_PER_ROW = FB_WIDTH/8
FB_HEIGHT, 32, framebuffer height in rows; FB_BYTES = FB_BYTES_PER_ROW*FB_HEIGHT
FB_OFFSET, 12'h100, memory address of framebuffer byte 0 (row-major, MSB = leftmost pixel)
ADDR_W, 12, memory address width
WRAP, 1, 1 = pixels/rows past the edge wrap modulo width/height; 0 = clipped (no access)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
gpu_cmd  in  4  command code: 4'h1 CLEAR, 4'h2 DRAW, others ignored
gpu_draw_offset  in  16  sprite base address; low ADDR_W bits used
gpu_draw_x  in  8  sprite x, taken modulo FB_WIDTH
gpu_draw_y  in  8  sprite y, taken modulo FB_HEIGHT
gpu_draw_length  in  8  sprite rows, 0..255
gpu_cmd_submitted  in  1  command strobe, sampled only while gpu_ready
gpu_ready  out  1  high iff state IDLE (combinational)
gpu_collision  out  1  sticky result of last DRAW
gpu_mem_read  out  1  read request, held until ack
gpu_mem_read_addr  out  ADDR_W  read address
gpu_mem_read_data  in  8  read data, valid in ack cycle
gpu_mem_read_ack  in  1  read complete
gpu_mem_write  out  1  one-cycle write strobe, always accepted
gpu_mem_write_addr  out  ADDR_W  write address
gpu_mem_write_data  out  8  write data

Behaviour:
- Reset (async, any state): state IDLE; all reg outputs 0; gpu_ready=1; any command in flight is abandoned.
- Command accept: at the rising edge where gpu_ready & gpu_cmd_submitted, latch cmd, offset, x mod W, y mod H and length -> DECODE. Inputs are don't-care afterwards.
- DECODE: CLEAR -> CLEAR with idx=0. DRAW -> clear gpu_collision, r=0 -> ROW. Other code -> IDLE, no memory access.
- CLEAR: gpu_mem_write=1, addr=FB_OFFSET+idx, data=0, idx ascending for FB_BYTES consecutive cycles. The first strobe is high in the 2nd cycle after the accept edge. gpu_ready rises in the cycle after the last strobe. No reads.
- ROW: if r==length -> IDLE. Row address yr=y0+r. If yr>=H: with WRAP=1, yr-=H (repeat modulo); with WRAP=0, the row and all remaining rows are skipped -> IDLE. Otherwise -> FETCH.
- FETCH: read (offset+r) truncated to ADDR_W; hold read/addr until ack; latch data as s.
- Byte split: bx=x0>>3, sh=x0&7. Left mask = s>>sh at byte bx. If sh!=0, right mask = s<<(8-sh) at byte bx+1. If bx+1==FB_BYTES_PER_ROW, WRAP=1 uses byte 0 of the same row; WRAP=0 drops the right part.
- For each part, left then right: RD_FB reads FB_OFFSET+yr*FB_BYTES_PER_ROW+byte and waits for ack. WR_FB writes old^mask as a one-cycle strobe. If (old&mask)!=0, set collision. A zero mask still performs the read/write. Then r++ -> ROW.
- gpu_mem_read and gpu_mem_write are never high in the same cycle. gpu_mem_read deasserts the cycle after ack. Ack while not reading is ignored.
- gpu_collision holds its value through IDLE and CLEAR. It changes only at DRAW decode (clear) or on a DRAW overlap (set). Length 0 -> IDLE, collision=0, no accesses.
- Address arithmetic is ADDR_W bits, wrapping silently.

Test Plan:
- Defaults, CLEAR -> exactly 256 strobes, addr 0x100..0x1FF ascending, data 0x00, no reads, gpu_ready high afterwards; a submit during CLEAR is ignored.
- DRAW x=8,y=0,len=1,offset=0x200, mem[0x200]=0xF0, fb zero -> read 0x200, read 0x101, write 0x101=0xF0, collision=0; ack delayed 3 cycles gives the same result.
- DRAW x=4,y=1,len=1, sprite 0xFF, fb zero -> writes 0x108=0x0F then 0x109=0xF0; repeating the DRAW -> writes 0x00,0x00, collision=1.
- WRAP=1, x=60,y=31,len=2, sprites 0xFF,0x81 -> row 31: 0x1FF^=0x0F, 0x1F8^=0xF0; row 0: 0x107^=0x08, 0x100^=0x10. WRAP=0 -> only 0x1FF^=0x0F.
- DRAW len=0 after a collision -> collision=0, no memory access, ready in 3 cycles; gpu_cmd=4'hF -> no accesses, collision unchanged.
- rst pulse while in RD_FB with gpu_mem_read high -> read/write low, ready=1, collision=0 immediately; next CLEAR runs normally.
